reg_dump_reader: RTL

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/reg_dump_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the register-dump reader: default geometry of the
// scanned register file and the dump FSM state encoding.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (adds the CSUM state and the
// trailing XOR checksum word).
package riscv_pkg;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } dump_state_t;
`else
  localparam bit CHECKSUM_EN = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd4
  } dump_state_t;
`endif

endpackage : riscv_pkg

// File: rtl/reg_dump_reader.sv
// Register-dump reader: walks register indices 0..NUM_REGS-1, reads each one
// through a combinational register-file port and streams it out over a
// valid/ready interface, then pulses done.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends the XOR of all streamed
// words as a final word (out_idx = 0, out_last = 1).
// NUM_REGS must not exceed 2**ADDR_WIDTH; the index never wraps.
module reg_dump_reader
  import riscv_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_t state;
  dump_state_t state_next;

  logic [ADDR_WIDTH-1:0] index;   // register currently being read/sent
  logic [DATA_WIDTH-1:0] data_q;  // captured register word
  logic [ADDR_WIDTH-1:0] idx_q;   // index that data_q came from

  logic idx_clr;    // return index (and checksum) to zero
  logic idx_inc;    // advance to the next register
  logic word_load;  // capture rf_data into the output word registers

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;  // running XOR of every word read this dump
`endif

  // State register; reset drops any dump in progress immediately.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, datapath controls and stream outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    word_load  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = data_q;
    out_idx    = idx_q;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_READ;
        end
      end

      S_READ: begin
        word_load  = 1'b1;
        state_next = S_SEND;
      end

      S_SEND: begin
        out_valid = 1'b1;
`ifndef REG_DUMP_CHECKSUM_EN
        out_last  = (idx_q == LAST_IDX);
`endif
        if (out_ready) begin
          if (index == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
          end else begin
            idx_inc    = 1'b1;
            state_next = S_READ;
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = csum_q;
        out_idx   = '0;
        if (out_ready) begin
          state_next = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
      idx_inc    = 1'b0;
      word_load  = 1'b0;
    end

    // Index sits at zero throughout IDLE and is zero on entry to a new dump.
    if ((state == S_IDLE) || (state_next == S_IDLE)) begin
      idx_clr = 1'b1;
    end
  end

  // Index counter and captured output word.
  // NOTE: the datapath registers are reset too, because out_data/out_idx are
  // architecturally visible and must read zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index  <= '0;
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      if (idx_clr) begin
        index <= '0;
      end else if (idx_inc) begin
        index <= index + ADDR_WIDTH'(1);
      end
      if (word_load) begin
        data_q <= rf_data;
        idx_q  <= index;
      end
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Running checksum over the words captured in this dump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (idx_clr) begin
      csum_q <= '0;
    end else if (word_load) begin
      csum_q <= csum_q ^ rf_data;
    end
  end
`endif

  // Status and register-file address decode.
  always_comb begin
    rf_addr = index;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

endmodule : reg_dump_reader
